mem_wb_pipe: RTL and testbench

- Parametrised successor to the fixed 32-bit MEM/WB register.
- Selects the writeback result (memory data or ALU result) and holds it in a 2-entry elastic skid buffer with valid/ready handshakes on both sides.
- Adds flush, writes to register 0 suppressed, and a forwarding tap for the hazard unit.
- Sits between the MEM stage and the register-file write port.

---
 rtl/mem_wb_pkg.sv | 32 +++
 rtl/mem_wb_load_fmt.sv | 31 +++
 rtl/mem_wb_pipe.sv | 118 +++++++++++
 tb/tb_mem_wb_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM/WB writeback skid buffer: load sizes, buffer states
// and the default-width writeback entry seen by the hazard unit.
package mem_wb_pkg;

  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10
  } ld_size_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } wb_state_e;

  localparam int WB_XLEN_DEF    = 32;
  localparam int WB_RADDR_W_DEF = 4;

  // Default-width entry; the pipe declares a parameter-sized twin internally.
  typedef struct packed {
    logic [WB_XLEN_DEF-1:0]    result;
    logic [WB_RADDR_W_DEF-1:0] wn;
    logic                      en_rw;
  } wb_entry_t;

  function automatic logic wb_keep_en(input logic en_rw, input logic wn_is_zero,
                                      input logic suppress);
    return en_rw & ~(suppress & wn_is_zero);
  endfunction

endpackage

// File: rtl/mem_wb_load_fmt.sv
// Load formatter: picks the addressed byte/halfword lane out of the memory word
// and sign- or zero-extends it. Only instantiated with MEM_WB_LOAD_EXT_EN.
module mem_wb_load_fmt
  import mem_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      ld_size,
  input  logic            ld_uns,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data_fmt
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sx;

  always_comb begin
    lane_b   = data[{addr_lo, 3'b000} +: 8];
    lane_h   = addr_lo[1] ? data[31:16] : data[15:0];
    sx       = ~ld_uns;
    data_fmt = data;
    case (ld_size)
      LD_B:    data_fmt = {{(XLEN-8){sx & lane_b[7]}}, lane_b};
      LD_H:    data_fmt = {{(XLEN-16){sx & lane_h[15]}}, lane_h};
      default: data_fmt = data;  // word, and 2'b11 treated as word
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB writeback register as a 2-entry elastic skid buffer with flush,
// r0 write suppression and a forwarding tap. Optional load formatting on the
// memory path is enabled by defining MEM_WB_LOAD_EXT_EN.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RADDR_W     = 4,
  parameter int R0_SUPPRESS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    alu_in,
  input  logic [XLEN-1:0]    mem_in,
  input  logic [RADDR_W-1:0] wn_in,
  input  logic               mreg_in,
  input  logic               en_rw_in,
  input  logic [1:0]         ld_size_in,
  input  logic               ld_uns_in,
  input  logic [1:0]         addr_lo_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result_out,
  output logic [RADDR_W-1:0] wn_out,
  output logic               en_rw_out,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_wn,
  output logic [XLEN-1:0]    fwd_data
);

  typedef struct packed {
    logic [XLEN-1:0]    result;
    logic [RADDR_W-1:0] wn;
    logic               en_rw;
  } entry_t;

  wb_state_e       state, state_nxt;
  entry_t          head, skid, new_e;
  logic            in_ready_q;
  logic            accept, pop;
  logic [XLEN-1:0] mem_fmt;

`ifdef MEM_WB_LOAD_EXT_EN
  mem_wb_load_fmt #(.XLEN(XLEN)) u_load_fmt (
    .data     (mem_in),
    .ld_size  (ld_size_in),
    .ld_uns   (ld_uns_in),
    .addr_lo  (addr_lo_in),
    .data_fmt (mem_fmt)
  );
`else
  logic unused_ld;
  assign mem_fmt   = mem_in;
  assign unused_ld = ^{ld_size_in, ld_uns_in, addr_lo_in};
`endif

  assign new_e.result = mreg_in ? mem_fmt : alu_in;
  assign new_e.wn     = wn_in;
  assign new_e.en_rw  = wb_keep_en(en_rw_in, wn_in == '0, R0_SUPPRESS != 0);

  assign out_valid = (state != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state_nxt = ONE;
        ONE: begin
          if (accept && !pop)      state_nxt = TWO;
          else if (pop && !accept) state_nxt = EMPTY;
        end
        TWO:     if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state so out_ready never reaches it
  // combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      head       <= '0;
      skid       <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != TWO);
      if (!flush) begin
        case (state)
          EMPTY: if (accept) head <= new_e;
          ONE: begin
            if (accept && pop)  head <= new_e;
            if (accept && !pop) skid <= new_e;
          end
          TWO:     if (pop) head <= skid;
          default: ;
        endcase
      end
    end
  end

  assign result_out = head.result;
  assign wn_out     = head.wn;
  assign en_rw_out  = head.en_rw & out_valid;
  assign fwd_valid  = out_valid & en_rw_out;
  assign fwd_wn     = wn_out;
  assign fwd_data   = result_out;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed scenarios plus random traffic
// compared against a queue-based FIFO reference model.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] alu_in, mem_in;
  logic [3:0]  wn_in;
  logic        mreg_in, en_rw_in;
  logic [1:0]  ld_size_in;
  logic        ld_uns_in;
  logic [1:0]  addr_lo_in;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] result_out;
  logic [3:0]  wn_out;
  logic        en_rw_out, fwd_valid;
  logic [3:0]  fwd_wn;
  logic [31:0] fwd_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  wn;
    logic        en_rw;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  mem_wb_pipe #(.XLEN(32), .RADDR_W(4), .R0_SUPPRESS(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_in     (alu_in),
    .mem_in     (mem_in),
    .wn_in      (wn_in),
    .mreg_in    (mreg_in),
    .en_rw_in   (en_rw_in),
    .ld_size_in (ld_size_in),
    .ld_uns_in  (ld_uns_in),
    .addr_lo_in (addr_lo_in),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_out (result_out),
    .wn_out     (wn_out),
    .en_rw_out  (en_rw_out),
    .fwd_valid  (fwd_valid),
    .fwd_wn     (fwd_wn),
    .fwd_data   (fwd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

`ifdef MEM_WB_LOAD_EXT_EN
  function automatic logic [31:0] fmt_load(input logic [31:0] m, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] a);
    int unsigned v;
    if (sz == 2'b00) begin
      v = (m >> (8 * a)) & 32'hFF;
      if (!uns && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (m >> (16 * (a / 2))) & 32'hFFFF;
      if (!uns && v >= 32768) v = v | 32'hFFFF_0000;
    end else begin
      v = m;
    end
    return v;
  endfunction
`endif

  function automatic logic [31:0] exp_result();
`ifdef MEM_WB_LOAD_EXT_EN
    return mreg_in ? fmt_load(mem_in, ld_size_in, ld_uns_in, addr_lo_in) : alu_in;
`else
    return mreg_in ? mem_in : alu_in;
`endif
  endfunction

  // Reference: bounded FIFO of two; capacity seen by in_ready is last cycle's.
  task automatic model_update();
    bit   acc, pp;
    exp_t e;
    if (!reset || flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      pp  = (q.size() > 0) && out_ready;
      if (pp) void'(q.pop_front());
      if (acc) begin
        e.result = exp_result();
        e.wn     = wn_in;
        e.en_rw  = en_rw_in && (wn_in != 4'd0);
        q.push_back(e);
      end
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    if (q.size() > 0) begin
      chk("result_out", result_out, q[0].result);
      chk("wn_out", {28'd0, wn_out}, {28'd0, q[0].wn});
      chk("en_rw_out", {31'd0, en_rw_out}, {31'd0, q[0].en_rw});
      chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, q[0].en_rw});
      chk("fwd_wn", {28'd0, fwd_wn}, {28'd0, q[0].wn});
      chk("fwd_data", fwd_data, q[0].result);
    end else begin
      chk("en_rw_out_idle", {31'd0, en_rw_out}, 32'd0);
      chk("fwd_valid_idle", {31'd0, fwd_valid}, 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [3:0] wn, input logic mreg, input logic en);
    in_valid = v;
    alu_in   = alu;
    mem_in   = mem;
    wn_in    = wn;
    mreg_in  = mreg;
    en_rw_in = en;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b1, 32'h5555_5555, 32'h6666_6666, 4'd7, 1'b0, 1'b1);
    ld_size_in = 2'b10; ld_uns_in = 1'b0; addr_lo_in = 2'b00;
    flush = 1'b0; out_ready = 1'b1;

    // reset held with in_valid asserted
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_result", result_out, 32'd0);
    chk("rst_wn", {28'd0, wn_out}, 32'd0);
    chk("rst_fwd", {27'd0, fwd_valid, fwd_wn}, 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);

    // first entry, one-cycle latency
    reset = 1'b1;
    drive(1'b1, 32'h1234, 32'h0, 4'd3, 1'b0, 1'b1);
    tick();
    chk("first_result", result_out, 32'h1234);
    chk("first_wn", {28'd0, wn_out}, 32'd3);
    chk("first_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    in_valid = 1'b0;
    tick();

    // back-pressure: A then B fill the buffer
    out_ready = 1'b0;
    drive(1'b1, 32'h0, 32'hAAAA_0000, 4'd5, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'hBBBB_0001, 32'h0, 4'd6, 1'b0, 1'b1);
    tick();
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'hCCCC_0002, 32'h0, 4'd8, 1'b0, 1'b1);
    repeat (2) tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_head_a", result_out, 32'hAAAA_0000);
    tick();
    chk("bp_head_b", result_out, 32'hBBBB_0001);
    repeat (2) tick();

    // streaming 8 back-to-back
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1000 + i, 32'h0, 4'(i + 1), 1'b0, 1'b1);
      tick();
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      chk("stream_data", result_out, 32'h1000 + i);
    end
    in_valid = 1'b0;
    tick();

    // writes to r0 suppressed, result still delivered
    drive(1'b1, 32'hFEED_0000, 32'h0, 4'd0, 1'b0, 1'b1);
    tick();
    chk("r0_en_rw", {31'd0, en_rw_out}, 32'd0);
    chk("r0_result", result_out, 32'hFEED_0000);
    in_valid = 1'b0;
    tick();

    // flush while full, input in the same cycle is dropped
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_1111, 32'h0, 4'd1, 1'b0, 1'b1);
    repeat (2) tick();
    drive(1'b1, 32'hDEAD_BEEF, 32'h0, 4'd9, 1'b0, 1'b1);
    flush = 1'b1;
    tick();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

`ifdef MEM_WB_LOAD_EXT_EN
    drive(1'b1, 32'h0, 32'h80FF_7F01, 4'd2, 1'b1, 1'b1);
    ld_size_in = 2'b00; addr_lo_in = 2'd3; ld_uns_in = 1'b0;
    tick();
    chk("ld_b_signed", result_out, 32'hFFFF_FF80);
    ld_uns_in = 1'b1;
    tick();
    chk("ld_b_unsigned", result_out, 32'h0000_0080);
    ld_size_in = 2'b01; addr_lo_in = 2'd2; ld_uns_in = 1'b0;
    tick();
    chk("ld_h_signed", result_out, 32'hFFFF_80FF);
    in_valid = 1'b0;
    tick();
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, 4'($urandom_range(0, 15)),
            1'($urandom), $urandom_range(0, 4) != 0);
      ld_size_in = 2'($urandom);
      ld_uns_in  = 1'($urandom);
      addr_lo_in = 2'($urandom);
      out_ready  = $urandom_range(0, 2) != 0;
      flush      = $urandom_range(0, 31) == 0;
      tick();
    end

    // drain
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
